// File: rtl/core_program_loader_if.sv
// Byte-stream handshake between a host byte source (e.g. a UART receiver) and the loader.
// Latency: none, wires only.
// Backpressure: the slave deasserts o_rx_ready; a byte moves on i_rx_valid && o_rx_ready.
//
// Signals:
//   i_rx_data  - stream byte (source -> loader)
//   i_rx_valid - byte valid (source -> loader)
//   o_rx_ready - loader can accept a byte (loader -> source)
interface core_program_loader_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       o_rx_ready;

    modport master (
        output i_rx_data,
        output i_rx_valid,
        input  o_rx_ready
    );

    modport slave (
        input  i_rx_data,
        input  i_rx_valid,
        output o_rx_ready
    );
endinterface

// File: rtl/core_program_loader.sv
// Boot loader: turns a little-endian byte packet into core setup-phase writes, then releases setup and pulses run.
// Latency: each instruction/register write is presented (registered) on the edge that accepts the word's 4th byte.
// Backpressure: ready in header/address/load states; ready drops in FLUSH, DONE and ERROR (no bytes taken).
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   rx (slave)           - byte stream: i_rx_data, i_rx_valid, o_rx_ready
//   o_setup              - holds core in setup mode
//   o_pc_start_addr      - start PC taken from packet word 1
//   o_inst_mem_addr/data - instruction write, o_inst_wr_strobe marks a new word
//   o_load_reg_addr/data - register preload, o_reg_wr_strobe marks a new word
//   o_run                - one-cycle pulse on entering DONE
//   o_done, o_error      - sticky completion / protocol error
//   o_words_loaded       - instruction words written so far
module core_program_loader #(
    parameter int         MAX_INSTR_WORDS = 1024,
    parameter logic [7:0] CMD_LOAD        = 8'hA5,
    parameter int         TIMEOUT_CYCLES  = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    core_program_loader_if.slave   rx,
    output logic                   o_setup,
    output logic [31:0]            o_pc_start_addr,
    output logic [31:0]            o_inst_mem_addr,
    output logic [31:0]            o_inst_mem_data,
    output logic                   o_inst_wr_strobe,
    output logic [4:0]             o_load_reg_addr,
    output logic [31:0]            o_load_reg_data,
    output logic                   o_reg_wr_strobe,
    output logic                   o_run,
    output logic                   o_done,
    output logic                   o_error,
    output logic [15:0]            o_words_loaded
);

    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0]   MAX_N     = 17'(MAX_INSTR_WORDS);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_WAIT_HDR   = 3'd0,
        S_WAIT_ADDR  = 3'd1,
        S_LOAD_INSTR = 3'd2,
        S_LOAD_REGS  = 3'd3,
        S_FLUSH      = 3'd4,
        S_DONE       = 3'd5,
        S_ERROR      = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   buf_q, buf_d;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic [15:0]   n_q, n_d;
    logic [4:0]    r_q, r_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inst_addr_q, inst_addr_d;
    logic [31:0]   inst_data_q, inst_data_d;
    logic [15:0]   words_q, words_d;
    logic [4:0]    reg_addr_q, reg_addr_d;
    logic [31:0]   reg_data_q, reg_data_d;
    logic          inst_stb_q, inst_stb_d;
    logic          reg_stb_q, reg_stb_d;
    logic          run_q, run_d;

    logic          rx_ready;
    logic          accept;
    logic          word_done;
    logic [31:0]   word;
    logic          hdr_ok;
    logic          counting;
    logic          tmo_fire;
    logic          last_instr;
    logic          last_reg;

    // ------------------------------------------------------------------
    // Byte handshake and word assembly
    // ------------------------------------------------------------------
    assign accept    = rx.i_rx_valid && rx_ready;
    assign word_done = accept && (byte_cnt_q == 2'd3);
    // Completed word: the current (4th) byte is the top byte.
    assign word      = {rx.i_rx_data, buf_q};

    assign hdr_ok = (word[31:24] == CMD_LOAD)
                 && (word[15:0] != 16'd0)
                 && ({1'b0, word[15:0]} <= MAX_N)
                 && (word[23:16] <= 8'd31);

    assign last_instr = ((words_q + 16'd1) == n_q);
    assign last_reg   = ((reg_addr_q + 5'd1) == r_q);

    // Idle in WAIT_HDR between packets must not time out; only a partial header counts.
    assign counting = (state_q == S_WAIT_ADDR) || (state_q == S_LOAD_INSTR)
                   || (state_q == S_LOAD_REGS)
                   || ((state_q == S_WAIT_HDR) && (byte_cnt_q != 2'd0));
    assign tmo_inc  = tmo_q + 1'b1;
    // An accepted byte on the same edge always wins over the timeout.
    assign tmo_fire = counting && !accept && (tmo_inc == TMO_LIMIT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_HDR: begin
                if (word_done) state_d = hdr_ok ? S_WAIT_ADDR : S_ERROR;
            end
            S_WAIT_ADDR: begin
                if (word_done) state_d = (word[1:0] == 2'b00) ? S_LOAD_INSTR : S_ERROR;
            end
            S_LOAD_INSTR: begin
                if (word_done && last_instr) state_d = (r_q != 5'd0) ? S_LOAD_REGS : S_FLUSH;
            end
            S_LOAD_REGS: begin
                if (word_done && last_reg) state_d = S_FLUSH;
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = state_q;
        endcase
        if (tmo_fire) state_d = S_ERROR;
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        rx_ready = 1'b0;
        o_setup  = 1'b1;
        o_done   = 1'b0;
        o_error  = 1'b0;
        case (state_q)
            S_WAIT_HDR, S_WAIT_ADDR, S_LOAD_INSTR, S_LOAD_REGS: rx_ready = 1'b1;
            S_DONE: begin
                o_setup = 1'b0;
                o_done  = 1'b1;
            end
            S_ERROR: o_error = 1'b1;
            default: ;
        endcase
    end

    assign rx.o_rx_ready = rx_ready;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        buf_d       = buf_q;
        n_d         = n_q;
        r_d         = r_q;
        pc_d        = pc_q;
        inst_addr_d = inst_addr_q;
        inst_data_d = inst_data_q;
        words_d     = words_q;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        inst_stb_d  = 1'b0;
        reg_stb_d   = 1'b0;
        // run is high for exactly the first DONE cycle, i.e. the cycle after FLUSH.
        run_d       = (state_q == S_FLUSH);

        if (accept) begin
            tmo_d = '0;
        end else if (counting) begin
            tmo_d = tmo_inc;
        end else begin
            tmo_d = '0;
        end

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    buf_d[7:0]   = rx.i_rx_data;
                2'd1:    buf_d[15:8]  = rx.i_rx_data;
                2'd2:    buf_d[23:16] = rx.i_rx_data;
                default: ;
            endcase
        end

        if (word_done) begin
            case (state_q)
                S_WAIT_HDR: begin
                    if (hdr_ok) begin
                        n_d = word[15:0];
                        r_d = word[20:16];
                    end
                end
                S_WAIT_ADDR: begin
                    if (word[1:0] == 2'b00) pc_d = word;
                end
                S_LOAD_INSTR: begin
                    // words_q is the index i of this word; address wraps at 32 bits.
                    inst_addr_d = pc_q + {14'd0, words_q, 2'b00};
                    inst_data_d = word;
                    words_d     = words_q + 16'd1;
                    inst_stb_d  = 1'b1;
                end
                S_LOAD_REGS: begin
                    // Preload starts at x1; x0 is never targeted.
                    reg_addr_d = reg_addr_q + 5'd1;
                    reg_data_d = word;
                    reg_stb_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= 2'd0;
            buf_q       <= 24'd0;
            tmo_q       <= '0;
            n_q         <= 16'd0;
            r_q         <= 5'd0;
            pc_q        <= 32'd0;
            inst_addr_q <= 32'd0;
            inst_data_q <= 32'd0;
            words_q     <= 16'd0;
            reg_addr_q  <= 5'd0;
            reg_data_q  <= 32'd0;
            inst_stb_q  <= 1'b0;
            reg_stb_q   <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            buf_q       <= buf_d;
            tmo_q       <= tmo_d;
            n_q         <= n_d;
            r_q         <= r_d;
            pc_q        <= pc_d;
            inst_addr_q <= inst_addr_d;
            inst_data_q <= inst_data_d;
            words_q     <= words_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            inst_stb_q  <= inst_stb_d;
            reg_stb_q   <= reg_stb_d;
            run_q       <= run_d;
        end
    end

    assign o_pc_start_addr  = pc_q;
    assign o_inst_mem_addr  = inst_addr_q;
    assign o_inst_mem_data  = inst_data_q;
    assign o_inst_wr_strobe = inst_stb_q;
    assign o_load_reg_addr  = reg_addr_q;
    assign o_load_reg_data  = reg_data_q;
    assign o_reg_wr_strobe  = reg_stb_q;
    assign o_run            = run_q;
    assign o_words_loaded   = words_q;

endmodule

// File: tb/tb_core_program_loader.sv
// Self-checking bench for core_program_loader: scoreboarded instruction/register writes plus scenario tasks.
// Latency: n/a (testbench).
// Backpressure: byte driver holds valid until ready, bounded by a cycle budget.
module tb_core_program_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_setup;
    logic [31:0] o_pc_start_addr;
    logic [31:0] o_inst_mem_addr;
    logic [31:0] o_inst_mem_data;
    logic        o_inst_wr_strobe;
    logic [4:0]  o_load_reg_addr;
    logic [31:0] o_load_reg_data;
    logic        o_reg_wr_strobe;
    logic        o_run;
    logic        o_done;
    logic        o_error;
    logic [15:0] o_words_loaded;

    int compared = 0;
    int mismatched = 0;

    wr_t         inst_exp[$];
    wr_t         reg_exp[$];
    wr_t         mon_e;
    logic [31:0] last_inst_addr = 32'd0;

    core_program_loader_if rxif ();

    core_program_loader #(
        .MAX_INSTR_WORDS (1024),
        .CMD_LOAD        (8'hA5),
        .TIMEOUT_CYCLES  (50)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx               (rxif.slave),
        .o_setup          (o_setup),
        .o_pc_start_addr  (o_pc_start_addr),
        .o_inst_mem_addr  (o_inst_mem_addr),
        .o_inst_mem_data  (o_inst_mem_data),
        .o_inst_wr_strobe (o_inst_wr_strobe),
        .o_load_reg_addr  (o_load_reg_addr),
        .o_load_reg_data  (o_load_reg_data),
        .o_reg_wr_strobe  (o_reg_wr_strobe),
        .o_run            (o_run),
        .o_done           (o_done),
        .o_error          (o_error),
        .o_words_loaded   (o_words_loaded)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every strobe pops one expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (o_inst_wr_strobe === 1'b1) begin
                compared++;
                if (inst_exp.size() == 0) begin
                    mismatched++;
                    $display("FAIL inst_unexpected: addr=%h data=%h, required no strobe", o_inst_mem_addr, o_inst_mem_data);
                end else begin
                    mon_e = inst_exp.pop_front();
                    last_inst_addr = mon_e.addr;
                    if (o_inst_mem_addr !== mon_e.addr || o_inst_mem_data !== mon_e.data || o_load_reg_addr !== 5'd0) begin
                        mismatched++;
                        $display("FAIL inst_write: got addr=%h data=%h regaddr=%0d, required addr=%h data=%h regaddr=0",
                                 o_inst_mem_addr, o_inst_mem_data, o_load_reg_addr, mon_e.addr, mon_e.data);
                    end
                end
            end
            if (o_reg_wr_strobe === 1'b1) begin
                compared++;
                if (reg_exp.size() == 0) begin
                    mismatched++;
                    $display("FAIL reg_unexpected: addr=%0d data=%h, required no strobe", o_load_reg_addr, o_load_reg_data);
                end else begin
                    mon_e = reg_exp.pop_front();
                    if (o_load_reg_addr !== mon_e.addr[4:0] || o_load_reg_data !== mon_e.data || o_inst_mem_addr !== last_inst_addr) begin
                        mismatched++;
                        $display("FAIL reg_write: got addr=%0d data=%h instaddr=%h, required addr=%0d data=%h instaddr=%h",
                                 o_load_reg_addr, o_load_reg_data, o_inst_mem_addr, mon_e.addr[4:0], mon_e.data, last_inst_addr);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rxif.i_rx_valid = 1'b0;
        rxif.i_rx_data  = 8'h00;
        rst_n = 1'b0;
        repeat (2) tick();
        inst_exp.delete();
        reg_exp.delete();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        rxif.i_rx_valid = 1'b0;
        repeat (gap) tick();
        rxif.i_rx_data  = b;
        rxif.i_rx_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 60 && !ok; t++) begin
            if (rxif.o_rx_ready === 1'b1) ok = 1'b1;
            tick();
        end
        rxif.i_rx_valid = 1'b0;
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL byte_accept: byte %h not accepted within 60 cycles, required acceptance", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic send_packet(input logic [31:0] hdr, input logic [31:0] s,
                               input wq_t ins, input wq_t regs, input int maxgap);
        send_word(hdr, maxgap);
        send_word(s, maxgap);
        foreach (ins[i]) begin
            inst_exp.push_back(wr_t'{addr: s + 32'(4 * i), data: ins[i]});
            send_word(ins[i], maxgap);
        end
        foreach (regs[j]) begin
            reg_exp.push_back(wr_t'{addr: 32'(j + 1), data: regs[j]});
            send_word(regs[j], maxgap);
        end
    endtask

    // Observe a fixed window after the last byte; returns cycles with run high.
    task automatic settle(output int runs);
        runs = 0;
        repeat (6) begin
            tick();
            if (o_run === 1'b1) runs++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxif.i_rx_valid = 1'b0;
        rxif.i_rx_data  = 8'h00;
        #2;
        compared++;
        if (o_setup !== 1'b1 || rxif.o_rx_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_setup_ready: setup=%b ready=%b, required 1 1", o_setup, rxif.o_rx_ready);
        end
        compared++;
        if ({o_run, o_done, o_error, o_inst_wr_strobe, o_reg_wr_strobe} !== 5'b0 || o_words_loaded !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_flags: run/done/err/istb/rstb=%b words=%0d, required 0", {o_run, o_done, o_error, o_inst_wr_strobe, o_reg_wr_strobe}, o_words_loaded);
        end
        compared++;
        if (o_pc_start_addr !== 32'd0 || o_inst_mem_addr !== 32'd0 || o_inst_mem_data !== 32'd0
            || o_load_reg_addr !== 5'd0 || o_load_reg_data !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_bus: pc=%h ia=%h id=%h ra=%0d rd=%h, required all 0", o_pc_start_addr, o_inst_mem_addr, o_inst_mem_data, o_load_reg_addr, o_load_reg_data);
        end
        do_reset();
    endtask

    task automatic test_basic_load();
        wq_t ins;
        wq_t none;
        do_reset();
        ins.push_back(32'h00500093);
        ins.push_back(32'h00A00113);
        send_packet(32'hA500_0002, 32'h0000_0100, ins, none, 0);
        // Now in FLUSH: last write on the bus, setup still high, no bytes taken.
        compared++;
        if (o_setup !== 1'b1 || rxif.o_rx_ready !== 1'b0 || o_done !== 1'b0 || o_inst_wr_strobe !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_flush: setup=%b ready=%b done=%b istb=%b, required 1 0 0 1", o_setup, rxif.o_rx_ready, o_done, o_inst_wr_strobe);
        end
        tick();
        compared++;
        if (o_setup !== 1'b0 || o_run !== 1'b1 || o_done !== 1'b1 || o_pc_start_addr !== 32'h100) begin
            mismatched++;
            $display("FAIL basic_done: setup=%b run=%b done=%b pc=%h, required 0 1 1 00000100", o_setup, o_run, o_done, o_pc_start_addr);
        end
        tick();
        compared++;
        if (o_run !== 1'b0 || o_done !== 1'b1 || o_words_loaded !== 16'd2 || rxif.o_rx_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_after: run=%b done=%b words=%0d ready=%b, required 0 1 2 0", o_run, o_done, o_words_loaded, rxif.o_rx_ready);
        end
        compared++;
        if (inst_exp.size() != 0) begin
            mismatched++;
            $display("FAIL basic_sb_empty: %0d writes outstanding, required 0", inst_exp.size());
        end
    endtask

    task automatic test_reg_preload();
        wq_t ins;
        wq_t regs;
        int  runs;
        do_reset();
        ins.push_back(32'h1234_5678);
        regs.push_back(32'h1111_1111);
        regs.push_back(32'h2222_2222);
        send_packet(32'hA502_0001, 32'h0000_0200, ins, regs, 0);
        settle(runs);
        compared++;
        if (o_done !== 1'b1 || runs != 1 || o_words_loaded !== 16'd1 || o_load_reg_addr !== 5'd2) begin
            mismatched++;
            $display("FAIL regs_done: done=%b runs=%0d words=%0d regaddr=%0d, required 1 1 1 2", o_done, runs, o_words_loaded, o_load_reg_addr);
        end
        compared++;
        if (inst_exp.size() != 0 || reg_exp.size() != 0) begin
            mismatched++;
            $display("FAIL regs_sb_empty: inst=%0d reg=%0d outstanding, required 0 0", inst_exp.size(), reg_exp.size());
        end
    endtask

    task automatic test_protocol_errors();
        logic [31:0] hdrs [5] = '{32'h5A00_0002, 32'hA500_0000, 32'hA500_0401, 32'hA520_0001, 32'hA500_0001};
        for (int c = 0; c < 5; c++) begin
            do_reset();
            send_word(hdrs[c], 0);
            if (c == 4) send_word(32'h0000_0102, 0);
            compared++;
            if (o_error !== 1'b1 || rxif.o_rx_ready !== 1'b0 || o_setup !== 1'b1 || o_done !== 1'b0) begin
                mismatched++;
                $display("FAIL err_case%0d: error=%b ready=%b setup=%b done=%b, required 1 0 1 0", c, o_error, rxif.o_rx_ready, o_setup, o_done);
            end
            // Keep offering bytes; the monitor flags any strobe as unexpected.
            rxif.i_rx_valid = 1'b1;
            rxif.i_rx_data  = 8'h13;
            repeat (10) tick();
            rxif.i_rx_valid = 1'b0;
            compared++;
            if (o_error !== 1'b1 || o_words_loaded !== 16'd0 || o_run !== 1'b0) begin
                mismatched++;
                $display("FAIL err_sticky%0d: error=%b words=%0d run=%b, required 1 0 0", c, o_error, o_words_loaded, o_run);
            end
        end
    endtask

    task automatic test_gaps();
        wq_t ins;
        wq_t none;
        int  runs;
        do_reset();
        ins.push_back(32'h00500093);
        ins.push_back(32'h00A00113);
        send_packet(32'hA500_0002, 32'h0000_0100, ins, none, 20);
        settle(runs);
        compared++;
        if (o_done !== 1'b1 || o_error !== 1'b0 || runs != 1 || o_words_loaded !== 16'd2
            || o_pc_start_addr !== 32'h100 || o_setup !== 1'b0 || inst_exp.size() != 0) begin
            mismatched++;
            $display("FAIL gaps_result: done=%b err=%b runs=%0d words=%0d pc=%h setup=%b left=%0d, required 1 0 1 2 00000100 0 0",
                     o_done, o_error, runs, o_words_loaded, o_pc_start_addr, o_setup, inst_exp.size());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_word(32'hA500_0002, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        repeat (49) tick();
        compared++;
        if (o_error !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_early: error=%b after 49 idle cycles, required 0", o_error);
        end
        tick();
        compared++;
        if (o_error !== 1'b1 || rxif.o_rx_ready !== 1'b0 || o_setup !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_fire: error=%b ready=%b setup=%b after 50 idle cycles, required 1 0 1", o_error, rxif.o_rx_ready, o_setup);
        end
    endtask

    task automatic test_reset_mid();
        wq_t ins;
        wq_t none;
        int  runs;
        do_reset();
        send_word(32'hA500_0002, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        rst_n = 1'b0;
        #2;
        compared++;
        if (o_setup !== 1'b1 || rxif.o_rx_ready !== 1'b1 || o_pc_start_addr !== 32'd0 || o_error !== 1'b0 || o_words_loaded !== 16'd0) begin
            mismatched++;
            $display("FAIL midreset_vals: setup=%b ready=%b pc=%h err=%b words=%0d, required 1 1 0 0 0", o_setup, rxif.o_rx_ready, o_pc_start_addr, o_error, o_words_loaded);
        end
        tick();
        rst_n = 1'b1;
        tick();
        ins.push_back(32'hDEAD_BEEF);
        ins.push_back(32'h0BAD_F00D);
        send_packet(32'hA500_0002, 32'h0000_0100, ins, none, 0);
        settle(runs);
        compared++;
        if (o_done !== 1'b1 || runs != 1 || o_words_loaded !== 16'd2 || o_pc_start_addr !== 32'h100 || inst_exp.size() != 0) begin
            mismatched++;
            $display("FAIL midreset_reload: done=%b runs=%0d words=%0d pc=%h left=%0d, required 1 1 2 00000100 0", o_done, runs, o_words_loaded, o_pc_start_addr, inst_exp.size());
        end
    endtask

    task automatic test_addr_wrap();
        wq_t ins;
        wq_t none;
        int  runs;
        do_reset();
        ins.push_back(32'hAAAA_0001);
        ins.push_back(32'hBBBB_0002);
        send_packet(32'hA500_0002, 32'hFFFF_FFFC, ins, none, 0);
        settle(runs);
        compared++;
        if (o_done !== 1'b1 || runs != 1 || o_inst_mem_addr !== 32'h0 || o_pc_start_addr !== 32'hFFFF_FFFC || inst_exp.size() != 0) begin
            mismatched++;
            $display("FAIL wrap_result: done=%b runs=%0d lastaddr=%h pc=%h left=%0d, required 1 1 00000000 fffffffc 0", o_done, runs, o_inst_mem_addr, o_pc_start_addr, inst_exp.size());
        end
    endtask

    initial begin
        rxif.i_rx_valid = 1'b0;
        rxif.i_rx_data  = 8'h00;
        test_reset();
        test_basic_load();
        test_reg_preload();
        test_protocol_errors();
        test_gaps();
        test_timeout();
        test_reset_mid();
        test_addr_wrap();
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
